// File: rtl/lcd_msg_formatter.sv
// Formats a bulls/cows guess result into a 16-char LCD line and pulses submit.
// Optional attempt counter "Txx" in chars 0-2 is enabled by LCDFMT_TRIES_EN.
module lcd_msg_formatter #(
  parameter int SUBMIT_HOLD = 4,
  parameter int GAP         = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        result_valid,
  input  logic [15:0] guess,
  input  logic [2:0]  bulls,
  input  logic [2:0]  cows,
  input  logic        new_game,
  output logic [7:0]  ascii0,
  output logic [7:0]  ascii1,
  output logic [7:0]  ascii2,
  output logic [7:0]  ascii3,
  output logic [7:0]  ascii4,
  output logic [7:0]  ascii5,
  output logic [7:0]  ascii6,
  output logic [7:0]  ascii7,
  output logic [7:0]  ascii8,
  output logic [7:0]  ascii9,
  output logic [7:0]  ascii10,
  output logic [7:0]  ascii11,
  output logic [7:0]  ascii12,
  output logic [7:0]  ascii13,
  output logic [7:0]  ascii14,
  output logic [7:0]  ascii15,
  output logic        submit,
  output logic        busy,
  output logic        drop
);

  localparam logic [3:0]  HOLD_LAST = 4'(SUBMIT_HOLD - 1);
  localparam logic [20:0] GAP_LAST  = 21'(GAP - 1);
  localparam logic [7:0]  SP        = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUILD,
    S_ASSERT,
    S_GAP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  hold_cnt;
  logic [20:0] gap_cnt;
  logic        accept;

  logic [15:0] guess_q;
  logic [2:0]  bulls_q;
  logic [2:0]  cows_q;

  logic [7:0]  line    [16];
  logic [7:0]  line_nx [16];

  assign accept = (state == S_IDLE) && result_valid;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (result_valid) state_nx = S_BUILD;
      S_BUILD:  state_nx = S_ASSERT;
      S_ASSERT: if (hold_cnt == HOLD_LAST) state_nx = S_GAP;
      S_GAP:    if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
    endcase
  end

  // submit/busy are registered from next state so they never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      submit <= 1'b0;
      busy   <= 1'b0;
      drop   <= 1'b0;
    end else begin
      state  <= state_nx;
      submit <= (state_nx == S_ASSERT);
      busy   <= (state_nx != S_IDLE);
      drop   <= result_valid && (state != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      hold_cnt <= (state == S_ASSERT) ? hold_cnt + 4'd1 : 4'd0;
      gap_cnt  <= (state == S_GAP) ? gap_cnt + 21'd1 : 21'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guess_q <= '0;
      bulls_q <= '0;
      cows_q  <= '0;
    end else if (accept) begin
      guess_q <= guess;
      bulls_q <= bulls;
      cows_q  <= cows;
    end
  end

`ifdef LCDFMT_TRIES_EN
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] lat_tens;
  logic [3:0] lat_ones;
  logic [3:0] base_t;
  logic [3:0] base_o;
  logic [3:0] inc_t;
  logic [3:0] inc_o;

  // new_game coinciding with an accept counts from 00, giving 01
  always_comb begin
    base_t = new_game ? 4'd0 : tens;
    base_o = new_game ? 4'd0 : ones;
    inc_t  = base_t;
    inc_o  = base_o;
    if (!(base_t == 4'd9 && base_o == 4'd9)) begin
      if (base_o == 4'd9) begin
        inc_o = 4'd0;
        inc_t = base_t + 4'd1;
      end else begin
        inc_o = base_o + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens     <= '0;
      ones     <= '0;
      lat_tens <= '0;
      lat_ones <= '0;
    end else if (accept) begin
      tens     <= inc_t;
      ones     <= inc_o;
      lat_tens <= inc_t;
      lat_ones <= inc_o;
    end else if (new_game) begin
      tens <= '0;
      ones <= '0;
    end
  end
`else
  logic unused_new_game;
  assign unused_new_game = new_game;
`endif

  function automatic logic [7:0] dchar(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : 8'h30 + {4'h0, d};
  endfunction

  logic [3:0] sum;
  logic       err;
  logic       win;

  assign sum = {1'b0, bulls_q} + {1'b0, cows_q};
  assign err = (bulls_q > 3'd4) || (cows_q > 3'd4) || (sum > 4'd4);
  assign win = (bulls_q == 3'd4) && (cows_q == 3'd0);

  always_comb begin
    for (int i = 0; i < 16; i++) line_nx[i] = SP;
`ifdef LCDFMT_TRIES_EN
    line_nx[0] = 8'h54;
    line_nx[1] = dchar(lat_tens);
    line_nx[2] = dchar(lat_ones);
`endif
    line_nx[4] = dchar(guess_q[15:12]);
    line_nx[5] = dchar(guess_q[11:8]);
    line_nx[6] = dchar(guess_q[7:4]);
    line_nx[7] = dchar(guess_q[3:0]);
    if (win) begin
      line_nx[9]  = 8'h57;
      line_nx[10] = 8'h49;
      line_nx[11] = 8'h4E;
      line_nx[12] = 8'h21;
    end else if (err) begin
      line_nx[9]  = 8'h45;
      line_nx[10] = 8'h52;
      line_nx[11] = 8'h52;
      line_nx[12] = SP;
    end else begin
      line_nx[9]  = 8'h30 + {5'h0, bulls_q};
      line_nx[10] = 8'h42;
      line_nx[11] = 8'h30 + {5'h0, cows_q};
      line_nx[12] = 8'h43;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) line[i] <= SP;
    end else if (state == S_BUILD) begin
      line <= line_nx;
    end
  end

  assign ascii0  = line[0];
  assign ascii1  = line[1];
  assign ascii2  = line[2];
  assign ascii3  = line[3];
  assign ascii4  = line[4];
  assign ascii5  = line[5];
  assign ascii6  = line[6];
  assign ascii7  = line[7];
  assign ascii8  = line[8];
  assign ascii9  = line[9];
  assign ascii10 = line[10];
  assign ascii11 = line[11];
  assign ascii12 = line[12];
  assign ascii13 = line[13];
  assign ascii14 = line[14];
  assign ascii15 = line[15];

endmodule

// File: tb/tb_lcd_msg_formatter.sv
// Bench for lcd_msg_formatter: table vectors, random results vs a string model,
// and hand sequences for drop, new_game, saturation and mid-transfer reset.
module tb_lcd_msg_formatter;

  localparam int HOLD = 4;
  localparam int GAPC = 20;

  logic        clk;
  logic        rst;
  logic        result_valid;
  logic [15:0] guess;
  logic [2:0]  bulls;
  logic [2:0]  cows;
  logic        new_game;
  logic [7:0]  a [16];
  logic        submit;
  logic        busy;
  logic        drop;

  int    n_checks;
  int    n_fail;
  int    attempts;
  string exp_line;

  lcd_msg_formatter #(
    .SUBMIT_HOLD(HOLD),
    .GAP(GAPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .result_valid(result_valid),
    .guess(guess),
    .bulls(bulls),
    .cows(cows),
    .new_game(new_game),
    .ascii0(a[0]),
    .ascii1(a[1]),
    .ascii2(a[2]),
    .ascii3(a[3]),
    .ascii4(a[4]),
    .ascii5(a[5]),
    .ascii6(a[6]),
    .ascii7(a[7]),
    .ascii8(a[8]),
    .ascii9(a[9]),
    .ascii10(a[10]),
    .ascii11(a[11]),
    .ascii12(a[12]),
    .ascii13(a[13]),
    .ascii14(a[14]),
    .ascii15(a[15]),
    .submit(submit),
    .busy(busy),
    .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] g;
    logic [2:0]  b;
    logic [2:0]  c;
    logic [31:0] dig;
    logic [31:0] sc;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string prefix(input int att);
`ifdef LCDFMT_TRIES_EN
    return $sformatf("T%02d", att);
`else
    return "   ";
`endif
  endfunction

  function automatic string model_line(input logic [15:0] g,
                                       input logic [2:0] b,
                                       input logic [2:0] c,
                                       input int att);
    string s;
    int    dg;
    s = {prefix(att), " "};
    for (int i = 3; i >= 0; i--) begin
      dg = int'((g >> (4 * i)) & 16'hF);
      if (dg > 9) s = {s, "?"};
      else s = {s, $sformatf("%0d", dg)};
    end
    s = {s, " "};
    if (b == 4 && c == 0) s = {s, "WIN!"};
    else if (b > 4 || c > 4 || int'(b) + int'(c) > 4) s = {s, "ERR "};
    else s = {s, $sformatf("%0dB%0dC", b, c)};
    return {s, "   "};
  endfunction

  function automatic string dut_line();
    string s;
    s = "";
    for (int i = 0; i < 16; i++) s = {s, $sformatf("%c", a[i])};
    return s;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input string exp);
    logic bad;
    bad = (exp.len() != 16);
    for (int i = 0; i < 16 && !bad; i++)
      if (a[i] !== exp[i]) bad = 1'b1;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got '%s' expected '%s'", name, dut_line(), exp);
    end
  endtask

  task automatic check_mid(input string name, input logic [31:0] dig,
                           input logic [31:0] sc);
    logic [31:0] ad;
    logic [31:0] as;
    ad = {a[4], a[5], a[6], a[7]};
    as = {a[9], a[10], a[11], a[12]};
    n_checks++;
    if (ad !== dig || as !== sc) begin
      n_fail++;
      $display("FAIL %s: got '%s'/'%s' expected '%s'/'%s'",
               name, ad, as, dig, sc);
    end
  endtask

  task automatic accept_msg(input logic [15:0] g, input logic [2:0] b,
                            input logic [2:0] c, input logic ng);
    int n;
    guess = g;
    bulls = b;
    cows = c;
    new_game = ng;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    new_game = 1'b0;
    guess = 16'($urandom);
    bulls = 3'($urandom);
    cows = 3'($urandom);
    attempts = ng ? 1 : (attempts < 99 ? attempts + 1 : 99);
    exp_line = model_line(g, b, c, attempts);
    check_bit("build_busy", busy, 1'b1);
    check_bit("build_submit", submit, 1'b0);
    tick();
    check_line("line_at_n2", exp_line);
    n = 0;
    while (submit && n < 20) begin
      n++;
      tick();
    end
    check_int("submit_hold", n, HOLD);
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy && k < GAPC + 50) begin
      k++;
      tick();
    end
  endtask

  initial begin
    int    k;
    string sv;
    n_checks = 0;
    n_fail = 0;
    attempts = 0;
    rst = 1'b1;
    result_valid = 1'b0;
    guess = '0;
    bulls = '0;
    cows = '0;
    new_game = 1'b0;

    tbl[0] = '{16'h1234, 3'd1, 3'd2, "1234", "1B2C"};
    tbl[1] = '{16'h5678, 3'd4, 3'd0, "5678", "WIN!"};
    tbl[2] = '{16'h9012, 3'd3, 3'd2, "9012", "ERR "};
    tbl[3] = '{16'h12A4, 3'd0, 3'd0, "12?4", "0B0C"};
    tbl[4] = '{16'hFFFF, 3'd5, 3'd0, "????", "ERR "};
    tbl[5] = '{16'h0000, 3'd0, 3'd4, "0000", "0B4C"};
    tbl[6] = '{16'h4321, 3'd2, 3'd2, "4321", "2B2C"};
    tbl[7] = '{16'h0987, 3'd0, 3'd5, "0987", "ERR "};

    repeat (3) tick();
    check_bit("rst_submit", submit, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_drop", drop, 1'b0);
    check_line("rst_line", "                ");
    rst = 1'b0;
    tick();
    check_bit("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      accept_msg(tbl[i].g, tbl[i].b, tbl[i].c, 1'b0);
      check_mid($sformatf("tbl%0d", i), tbl[i].dig, tbl[i].sc);
      wait_idle(k);
      check_int("gap_len", k, GAPC);
      check_line("line_stable", exp_line);
      if (i == 0) begin
`ifdef LCDFMT_TRIES_EN
        check_line("first_line", "T01 1234 1B2C   ");
`else
        check_line("first_line", "    1234 1B2C   ");
`endif
      end
    end

    accept_msg(16'h2468, 3'd1, 3'd1, 1'b0);
    repeat (4) tick();
    result_valid = 1'b1;
    guess = 16'h9999;
    tick();
    result_valid = 1'b0;
    check_bit("drop_pulse", drop, 1'b1);
    check_bit("drop_busy", busy, 1'b1);
    check_line("drop_line", exp_line);
    tick();
    check_bit("drop_clear", drop, 1'b0);
    wait_idle(k);
    check_int("drop_gap_rest", k, GAPC - 6);
    check_line("drop_line_end", exp_line);
    accept_msg(16'h1357, 3'd0, 3'd3, 1'b0);
    wait_idle(k);

    accept_msg(16'h8642, 3'd2, 3'd1, 1'b0);
    repeat (3) tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check_line("ng_gap_line", exp_line);
    wait_idle(k);
    check_int("ng_gap_len", k, GAPC - 4);
    check_line("ng_gap_line_end", exp_line);
    attempts = 0;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check_bit("ng_idle_busy", busy, 1'b0);
    tick();
    check_bit("ng_idle_submit", submit, 1'b0);
    accept_msg(16'h1111, 3'd1, 3'd0, 1'b0);
    wait_idle(k);

    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    attempts = 0;
    for (int i = 0; i < 100; i++) begin
      accept_msg(16'($urandom), 3'($urandom), 3'($urandom), 1'b0);
      wait_idle(k);
      check_int("rand_gap", k, GAPC);
    end
    sv = $sformatf("%c%c%c", a[0], a[1], a[2]);
    check_int("t99", int'(sv == prefix(99)), 1);
    accept_msg(16'h9876, 3'd0, 3'd1, 1'b0);
    wait_idle(k);
    sv = $sformatf("%c%c%c", a[0], a[1], a[2]);
    check_int("t99_sat", int'(sv == prefix(99)), 1);
    accept_msg(16'h4455, 3'd2, 3'd0, 1'b1);
    sv = $sformatf("%c%c%c", a[0], a[1], a[2]);
    check_int("ng_with_rv_t01", int'(sv == prefix(1)), 1);
    wait_idle(k);

    guess = 16'h3141;
    bulls = 3'd1;
    cows = 3'd1;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    tick();
    check_bit("pre_rst_submit", submit, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_bit("async_submit", submit, 1'b0);
    check_bit("async_busy", busy, 1'b0);
    check_line("async_line", "                ");
    tick();
    rst = 1'b0;
    attempts = 0;
    tick();
    accept_msg(16'h2718, 3'd0, 3'd2, 1'b0);
    sv = $sformatf("%c%c%c", a[0], a[1], a[2]);
    check_int("after_rst_t01", int'(sv == prefix(1)), 1);
    wait_idle(k);
    check_int("after_rst_gap", k, GAPC);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
